// File: rtl/otter_cache_pkg.sv
// Shared types and geometry helpers for the OTTER instruction cache.
// Field widths are derived from the line count and words per line.
package otter_cache_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int off_bits(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int words);
    return WORD_W - BYTE_OFF_W - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction storage: one synchronous write port used by line fills and
// one asynchronous read port so hits return in the same cycle as the PC.
module icache_data_array
  import otter_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  localparam int AW = $clog2(LINES * WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] rd_words [LINES*WORDS];

  generate
    for (genvar gi = 0; gi < LINES * WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (we && (waddr == AW'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign rd_words[gi] = word_reg;
    end
  endgenerate

  assign rdata = rd_words[raddr];

endmodule

// File: rtl/otter_icache.sv
// Direct-mapped read-only instruction cache for the OTTER fetch stage.
// Misses stall fetch and refill the whole line in order, one word per ack.
module otter_icache
  import otter_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] pc_i,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] instr_o,
  output logic              hit_o,
  output logic              stall_o,
  input  logic              inval_i,
  output logic              mem_req_o,
  output logic [WORD_W-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [WORD_W-1:0] miss_cnt_o
);

  localparam int OB = off_bits(WORDS);
  localparam int IB = idx_bits(LINES);
  localparam int TB = tag_bits(LINES, WORDS);

  logic [OB-1:0] pc_off;
  logic [IB-1:0] pc_idx;
  logic [TB-1:0] pc_tag;

  assign pc_off = pc_i[BYTE_OFF_W +: OB];
  assign pc_idx = pc_i[BYTE_OFF_W+OB +: IB];
  assign pc_tag = pc_i[WORD_W-1 -: TB];

  logic unused_byte_off;
  assign unused_byte_off = &{1'b0, pc_i[BYTE_OFF_W-1:0]};

  state_t            state_reg;
  logic [LINES-1:0]  valid_reg;
  logic [LINES-1:0]  valid_next;
  logic [OB-1:0]     cnt_reg;
  logic [IB-1:0]     fill_idx_reg;
  logic [TB-1:0]     fill_tag_reg;
  logic              pend_inval_reg;
  logic [WORD_W-1:0] miss_cnt_reg;
  logic              mem_req_reg;
  logic [WORD_W-1:0] mem_addr_reg;

  logic [TB-1:0] tag_mem [LINES];

  logic tag_match;
  logic miss_start;
  logic fill_ack;
  logic fill_last;

  assign tag_match  = (tag_mem[pc_idx] == pc_tag);
  assign hit_o      = valid_reg[pc_idx] & tag_match & (state_reg == IDLE);
  assign stall_o    = (rd_en_i & ~hit_o) | (state_reg == FILL);
  assign miss_start = (state_reg == IDLE) & rd_en_i & ~hit_o;
  assign fill_ack   = (state_reg == FILL) & mem_ack_i;
  assign fill_last  = fill_ack & (cnt_reg == OB'(WORDS - 1));

  // An invalidate that lands during a fill must also kill the line being filled.
  always_comb begin
    valid_next = valid_reg;
    if (state_reg == IDLE) begin
      if (inval_i) begin
        valid_next = '0;
      end
    end else if (fill_last) begin
      if (pend_inval_reg | inval_i) begin
        valid_next = '0;
      end else begin
        valid_next[fill_idx_reg] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      cnt_reg        <= '0;
      fill_idx_reg   <= '0;
      fill_tag_reg   <= '0;
      pend_inval_reg <= 1'b0;
      miss_cnt_reg   <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      case (state_reg)
        IDLE: begin
          if (miss_start) begin
            state_reg    <= FILL;
            fill_idx_reg <= pc_idx;
            fill_tag_reg <= pc_tag;
            cnt_reg      <= '0;
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= {pc_tag, pc_idx, {(OB+BYTE_OFF_W){1'b0}}};
          end
        end
        FILL: begin
          if (inval_i) begin
            pend_inval_reg <= 1'b1;
          end
          if (mem_ack_i) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == OB'(WORDS - 1)) begin
              state_reg      <= IDLE;
              mem_req_reg    <= 1'b0;
              pend_inval_reg <= 1'b0;
            end else begin
              mem_addr_reg <= mem_addr_reg + WORD_W'(4);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_last) begin
      tag_mem[fill_idx_reg] <= fill_tag_reg;
    end
  end

  icache_data_array #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_data (
    .clk  (CLK),
    .we   (fill_ack),
    .waddr({fill_idx_reg, cnt_reg}),
    .wdata(mem_data_i),
    .raddr({pc_idx, pc_off}),
    .rdata(instr_o)
  );

  assign mem_req_o  = mem_req_reg;
  assign mem_addr_o = mem_addr_reg;
  assign miss_cnt_o = miss_cnt_reg;

endmodule

// File: tb/tb_otter_icache.sv
// Directed bench for otter_icache: fills, hits, eviction, wait states,
// invalidation, redirect during fill and reset during fill.
module tb_otter_icache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] pc_i;
  logic        rd_en_i;
  logic [31:0] instr_o;
  logic        hit_o;
  logic        stall_o;
  logic        inval_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic [31:0] miss_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  otter_icache dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .pc_i      (pc_i),
    .rd_en_i   (rd_en_i),
    .instr_o   (instr_o),
    .hit_o     (hit_o),
    .stall_o   (stall_o),
    .inval_i   (inval_i),
    .mem_req_o (mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i (mem_ack_i),
    .miss_cnt_o(miss_cnt_o)
  );

  // Backing memory content: upper half is the inverted low address half.
  function automatic logic [31:0] model(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one missing fetch through its fill, acking every (gap+1) cycles.
  task automatic fetch_miss(input logic [31:0] addr, input int gap, input int exp_stall,
                            input bit exp_hit, input int redir_after, input logic [31:0] redir_pc,
                            input int inval_after, input int rst_after);
    int stalls = 0;
    int ackno = 0;
    int w = 0;
    bit done_redir = 0;
    bit done_inval = 0;
    bit did_rst = 0;
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    @(negedge CLK);
    pc_i = addr; rd_en_i = 1'b1; mem_ack_i = 1'b0; inval_i = 1'b0;
    #1;
    chk("miss_hit0", 32'(hit_o), 32'd0);
    chk("miss_stall1", 32'(stall_o), 32'd1);
    for (int c = 0; c < 400; c++) begin
      if (rst_after >= 0 && ackno == rst_after) begin
        RESET = 1'b1;
        #1;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_cnt", miss_cnt_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        did_rst = 1;
        break;
      end
      if (!stall_o || (ackno == 4 && !mem_req_o)) break;
      if (redir_after >= 0 && ackno == redir_after && !done_redir) begin
        pc_i = redir_pc; done_redir = 1;
      end
      if (inval_after >= 0 && ackno == inval_after && !done_inval) begin
        inval_i = 1'b1; done_inval = 1;
      end
      stalls++;
      if (mem_req_o) begin
        chk("fill_addr", mem_addr_o, base + 32'(4 * ackno));
        mem_data_i = model(mem_addr_o);
        if (w == gap) begin
          mem_ack_i = 1'b1; w = 0; ackno++;
        end else begin
          w++;
        end
      end
      @(negedge CLK);
      mem_ack_i = 1'b0; inval_i = 1'b0;
      #1;
    end
    if (!did_rst) begin
      chk("fill_words", 32'(ackno), 32'd4);
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
      chk("req_after_fill", 32'(mem_req_o), 32'd0);
      if (exp_hit) begin
        chk("hit_after_fill", 32'(hit_o), 32'd1);
        chk("instr_after_fill", instr_o, model(addr));
      end else begin
        chk("nohit_after_fill", 32'(hit_o), 32'd0);
      end
    end
    $display("[TB] miss 0x%08h: %0d stall cycles, %0d words, reset=%0d", addr, stalls, ackno, did_rst);
    rd_en_i = 1'b0;
  endtask

  task automatic miss(input logic [31:0] addr);
    fetch_miss(addr, 0, 5, 1'b1, -1, 32'h0, -1, -1);
  endtask

  task automatic fetch_hit(input logic [31:0] addr);
    @(negedge CLK);
    pc_i = addr; rd_en_i = 1'b1;
    #1;
    chk("hit", 32'(hit_o), 32'd1);
    chk("hit_stall", 32'(stall_o), 32'd0);
    chk("hit_instr", instr_o, model(addr));
    $display("[TB] hit  0x%08h: instr 0x%08h", addr, instr_o);
    rd_en_i = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; pc_i = 32'h0; rd_en_i = 1'b0; inval_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_req", 32'(mem_req_o), 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);
    chk("reset_misses", miss_cnt_o, 32'd0);
    chk("reset_hit", 32'(hit_o), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Cold miss with zero-wait memory, then hits in the same line.
    miss(32'h0000_0000);
    fetch_hit(32'h0000_0008);
    chk("word2_literal", instr_o, 32'hFFF7_0008);
    chk("misses_1", miss_cnt_o, 32'd1);

    // Conflict eviction on index 0.
    miss(32'h0000_0100);
    miss(32'h0000_0000);
    chk("misses_3", miss_cnt_o, 32'd3);

    // Ack every fourth cycle: 1 + 4*4 stall cycles.
    fetch_miss(32'h0000_0040, 3, 17, 1'b1, -1, 32'h0, -1, -1);
    fetch_hit(32'h0000_004C);
    fetch_hit(32'h0000_0000);

    // Invalidate in IDLE drops both lines.
    @(negedge CLK);
    rd_en_i = 1'b0; inval_i = 1'b1;
    @(negedge CLK);
    inval_i = 1'b0;
    miss(32'h0000_0000);
    miss(32'h0000_0040);
    chk("misses_6", miss_cnt_o, 32'd6);

    // Invalidate during a fill: fill completes but the line stays invalid.
    fetch_miss(32'h0000_0080, 0, 5, 1'b0, -1, 32'h0, 1, -1);
    miss(32'h0000_0080);

    // Redirect mid-fill: fill of 0x10 finishes, then 0x200 misses.
    fetch_miss(32'h0000_0010, 0, 5, 1'b0, 2, 32'h0000_0200, -1, -1);
    miss(32'h0000_0200);
    fetch_hit(32'h0000_0010);
    fetch_hit(32'h0000_0018);
    chk("misses_10", miss_cnt_o, 32'd10);

    // Reset after the second ack abandons the fill.
    fetch_miss(32'h0000_0000, 0, 5, 1'b1, -1, 32'h0, -1, 2);
    @(negedge CLK);
    RESET = 1'b0;
    miss(32'h0000_0000);
    chk("misses_after_reset", miss_cnt_o, 32'd1);
    miss(32'h0000_0010);

    // Acks outside a fill must not start a request or change state.
    @(negedge CLK);
    rd_en_i = 1'b0; mem_ack_i = 1'b1;
    @(negedge CLK);
    mem_ack_i = 1'b0;
    #1;
    chk("stray_ack_req", 32'(mem_req_o), 32'd0);
    fetch_hit(32'h0000_0000);
    chk("misses_2", miss_cnt_o, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
